// File: rtl/npc_mem_pkg.sv
// Shared constants and types for the NPC memory path: FSM encoding, LFSR
// taps/seed and strobe widths used by both initiator and responder sides.
package npc_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_e;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    localparam int MASK_W      = 4;
    localparam int PMEM_MASK_W = 8;

    // Wide enough for MIN_LAT (15) plus the largest random extra (15).
    localparam int CNT_W = 5;

endpackage

// File: rtl/pmem_dpi_pkg.sv
// Common pmem_read / pmem_write entry points shared by every pmem user,
// backed by a sparse word store; unwritten words read as zero.
package pmem_dpi_pkg;

    logic [31:0] mem [logic [31:0]];
    int unsigned n_reads  = 0;
    int unsigned n_writes = 0;
    logic [31:0] last_raddr = '0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [7:0]  last_wmask = '0;

    function automatic logic [31:0] pmem_read(input logic [31:0] raddr);
        n_reads++;
        last_raddr = raddr;
        return mem.exists(raddr) ? mem[raddr] : 32'h0;
    endfunction

    function automatic void pmem_write(input logic [31:0] waddr,
                                       input logic [31:0] wdata,
                                       input logic [7:0]  wmask);
        logic [31:0] word;
        n_writes++;
        last_waddr = waddr;
        last_wdata = wdata;
        last_wmask = wmask;
        word = mem.exists(waddr) ? mem[waddr] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
        end
        mem[waddr] = word;
    endfunction

endpackage

// File: rtl/pmem_if.sv
// Request/response channel between a memory initiator and pmem_responder.
interface pmem_if;
    import npc_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_wen;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_wen
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_wen
    );

endinterface

// File: rtl/pmem_responder_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free-running outside reset.
module lfsr8
    import npc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] out
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= seed;
        else     lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;

endmodule

// File: rtl/pmem_responder.sv
// Single-outstanding memory responder with fixed or LFSR-jittered latency
// between request accept and the pmem access.
//
//   state  | meaning
//   S_IDLE | ready for a request
//   S_WAIT | counting down the access delay; access fires when cnt hits 0
//   S_RESP | response held until rsp_ready
module pmem_responder
    import npc_mem_pkg::*;
    import pmem_dpi_pkg::*;
#(
    parameter int unsigned MIN_LAT   = 0,
    parameter int unsigned RAND_LAT  = 0,
    parameter int unsigned SPAN_LOG2 = 2,
    parameter logic [7:0]  LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic  clk,
    input  logic  rst,
    pmem_if.slave bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, lat_extra;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              wen_q, wen_d;
    logic              rsp_wen_q, rsp_wen_d;
    logic [31:0]       rdata_q;
    logic [7:0]        lfsr;
    logic              access;
    logic              unused_lfsr;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr)
    );

    assign unused_lfsr = ^lfsr;

    always_comb begin
        lat_extra = '0;
        if (RAND_LAT != 0) lat_extra[SPAN_LOG2-1:0] = lfsr[SPAN_LOG2-1:0];
    end

    assign access = (state_q == S_WAIT) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        wen_d     = wen_q;
        rsp_wen_d = access ? wen_q : rsp_wen_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr & ~32'h3;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    wen_d   = bus.req_wen;
                    cnt_d   = CNT_W'(MIN_LAT) + lat_extra;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) cnt_d   = cnt_q - CNT_W'(1);
                else             state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The memory call lives here so it happens exactly once, on the access
    // edge, and never on an edge where reset is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            wen_q     <= 1'b0;
            rsp_wen_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            wen_q     <= wen_d;
            rsp_wen_q <= rsp_wen_d;
            if (access) begin
                if (!wen_q) begin
                    rdata_q <= pmem_read(addr_q);
                end else begin
                    rdata_q <= '0;
                    if (wmask_q != '0) pmem_write(addr_q, wdata_q, {4'b0, wmask_q});
                end
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_wen   = rsp_wen_q;

endmodule
